// File: rtl/moldudp64_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : moldudp64_line_arbiter
// Purpose  : N-line MoldUDP64 arbiter; forwards each sequence number once,
//            drops duplicates and accepts gaps after a bounded wait.
// Revision : 1.0 - initial release
// ============================================================================
module moldudp64_line_arbiter #(
  parameter int N_CH     = 2,
  parameter int DATA_W   = 8,
  parameter int SEQ_W    = 64,
  parameter int GAP_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic                    clkIn,
  input  logic                    rstIn,
  input  logic [N_CH-1:0]         chValidIn,
  input  logic [N_CH*DATA_W-1:0]  chDataIn,
  input  logic [N_CH-1:0]         chLastIn,
  input  logic [N_CH*SEQ_W-1:0]   chSeqIn,
  output logic [N_CH-1:0]         chReadyOut,
  output logic                    itchDataValidOut,
  output logic [DATA_W-1:0]       itchDataOut,
  output logic                    itchLastOut,
  output logic [SEQ_W-1:0]        itchSeqOut,
  input  logic                    itchReadyIn,
  output logic                    packetLostOut,
  output logic [CNT_W-1:0]        gapCountOut,
  output logic [CNT_W-1:0]        dupCountOut
);

  localparam int c_SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int c_TMR_W = $clog2(GAP_WAIT + 1);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(GAP_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t               r_state, w_stateNext;
  logic [c_SEL_W-1:0]   r_sel, w_selNext;
  logic [c_TMR_W-1:0]   r_gapTmr, w_gapTmrNext;
  logic [SEQ_W-1:0]     r_expSeq;
  logic                 r_synced;
  logic                 r_outValid;
  logic [DATA_W-1:0]    r_outData;
  logic                 r_outLast;
  logic [SEQ_W-1:0]     r_outSeq;
  logic [CNT_W-1:0]     r_gapCount;
  logic [CNT_W-1:0]     r_dupCount;

  // Head classification, lowest index wins within each class
  logic                 w_hitInOrder, w_hitDup, w_anyValid;
  logic [c_SEL_W-1:0]   w_inOrderIdx, w_dupIdx, w_minIdx;
  logic [SEQ_W-1:0]     w_minSeq;

  always_comb begin
    w_hitInOrder = 1'b0;
    w_hitDup     = 1'b0;
    w_anyValid   = 1'b0;
    w_inOrderIdx = '0;
    w_dupIdx     = '0;
    w_minIdx     = '0;
    w_minSeq     = '1;
    for (int i = 0; i < N_CH; i++) begin
      if (chValidIn[i]) begin
        if (!w_hitInOrder && (!r_synced || chSeqIn[i*SEQ_W +: SEQ_W] == r_expSeq)) begin
          w_hitInOrder = 1'b1;
          w_inOrderIdx = c_SEL_W'(i);
        end
        if (!w_hitDup && (chSeqIn[i*SEQ_W +: SEQ_W] < r_expSeq)) begin
          w_hitDup = 1'b1;
          w_dupIdx = c_SEL_W'(i);
        end
        if (!w_anyValid || (chSeqIn[i*SEQ_W +: SEQ_W] < w_minSeq)) begin
          w_anyValid = 1'b1;
          w_minSeq   = chSeqIn[i*SEQ_W +: SEQ_W];
          w_minIdx   = c_SEL_W'(i);
        end
      end
    end
  end

  // Signals of the locked line
  logic                 w_selValid, w_selLast;
  logic [DATA_W-1:0]    w_selData;
  logic [SEQ_W-1:0]     w_selSeq;

  always_comb begin
    w_selValid = 1'b0;
    w_selLast  = 1'b0;
    w_selData  = '0;
    w_selSeq   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (c_SEL_W'(i) == r_sel) begin
        w_selValid = chValidIn[i];
        w_selLast  = chLastIn[i];
        w_selData  = chDataIn[i*DATA_W +: DATA_W];
        w_selSeq   = chSeqIn[i*SEQ_W +: SEQ_W];
      end
    end
  end

  logic w_selReady, w_accept, w_gapPulse;

  always_comb begin
    w_stateNext  = r_state;
    w_selNext    = r_sel;
    w_gapTmrNext = r_gapTmr;
    w_gapPulse   = 1'b0;
    w_selReady   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hitInOrder) begin
          w_selNext    = w_inOrderIdx;
          w_stateNext  = FWD;
          w_gapTmrNext = '0;
        end else if (w_hitDup) begin
          w_selNext    = w_dupIdx;
          w_stateNext  = DROP;
          w_gapTmrNext = '0;
        end else if (w_anyValid) begin
          // Only ahead-of-sequence heads: wait for another line to fill the gap
          if (r_gapTmr == c_TMR_LAST) begin
            w_selNext    = w_minIdx;
            w_stateNext  = FWD;
            w_gapPulse   = 1'b1;
            w_gapTmrNext = '0;
          end else begin
            w_gapTmrNext = r_gapTmr + c_TMR_W'(1);
          end
        end else begin
          w_gapTmrNext = '0;
        end
      end
      FWD: begin
        w_selReady = !r_outValid || itchReadyIn;
        if (w_selValid && w_selReady && w_selLast) w_stateNext = IDLE;
      end
      DROP: begin
        w_selReady = 1'b1;
        if (w_selValid && w_selLast) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign w_accept = w_selValid && w_selReady;

  always_comb begin
    chReadyOut = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (c_SEL_W'(i) == r_sel) chReadyOut[i] = w_selReady;
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_gapTmr   <= '0;
      r_expSeq   <= '0;
      r_synced   <= 1'b0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outLast  <= 1'b0;
      r_outSeq   <= '0;
      r_gapCount <= '0;
      r_dupCount <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_sel    <= w_selNext;
      r_gapTmr <= w_gapTmrNext;
      if (r_state == FWD && w_accept) begin
        r_outValid <= 1'b1;
        r_outData  <= w_selData;
        r_outLast  <= w_selLast;
        r_outSeq   <= w_selSeq;
        if (w_selLast) begin
          r_expSeq <= w_selSeq + SEQ_W'(1);
          r_synced <= 1'b1;
        end
      end else if (itchReadyIn) begin
        r_outValid <= 1'b0;
      end
      if (r_state == DROP && w_accept && w_selLast && r_dupCount != '1)
        r_dupCount <= r_dupCount + CNT_W'(1);
      if (w_gapPulse && r_gapCount != '1)
        r_gapCount <= r_gapCount + CNT_W'(1);
    end
  end

  assign itchDataValidOut = r_outValid;
  assign itchDataOut      = r_outData;
  assign itchLastOut      = r_outLast;
  assign itchSeqOut       = r_outSeq;
  assign packetLostOut    = w_gapPulse;
  assign gapCountOut      = r_gapCount;
  assign dupCountOut      = r_dupCount;

endmodule
`default_nettype wire

// File: tb/tb_moldudp64_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_moldudp64_line_arbiter
// Purpose  : Directed self-checking bench for moldudp64_line_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_moldudp64_line_arbiter;

  localparam int N_CH = 2;
  localparam int DATA_W = 8;
  localparam int SEQ_W = 64;
  localparam int GAP_WAIT = 64;
  localparam int CNT_W = 16;

  logic                   clkIn = 1'b0;
  logic                   rstIn;
  logic [N_CH-1:0]        chValidIn;
  logic [N_CH*DATA_W-1:0] chDataIn;
  logic [N_CH-1:0]        chLastIn;
  logic [N_CH*SEQ_W-1:0]  chSeqIn;
  logic [N_CH-1:0]        chReadyOut;
  logic                   itchDataValidOut;
  logic [DATA_W-1:0]      itchDataOut;
  logic                   itchLastOut;
  logic [SEQ_W-1:0]       itchSeqOut;
  logic                   itchReadyIn;
  logic                   packetLostOut;
  logic [CNT_W-1:0]       gapCountOut;
  logic [CNT_W-1:0]       dupCountOut;

  moldudp64_line_arbiter #(
    .N_CH(N_CH), .DATA_W(DATA_W), .SEQ_W(SEQ_W), .GAP_WAIT(GAP_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clkIn(clkIn), .rstIn(rstIn),
    .chValidIn(chValidIn), .chDataIn(chDataIn), .chLastIn(chLastIn), .chSeqIn(chSeqIn),
    .chReadyOut(chReadyOut),
    .itchDataValidOut(itchDataValidOut), .itchDataOut(itchDataOut),
    .itchLastOut(itchLastOut), .itchSeqOut(itchSeqOut), .itchReadyIn(itchReadyIn),
    .packetLostOut(packetLostOut), .gapCountOut(gapCountOut), .dupCountOut(dupCountOut)
  );

  always #5 clkIn = ~clkIn;

  int passCnt = 0;
  int totalCnt = 0;

  // Line sender model and output log
  logic        lnActive [N_CH];
  logic [63:0] lnSeq [N_CH];
  int          lnBeat [N_CH];
  int          lnLen [N_CH];
  logic [7:0]  logData [$];
  logic        logLast [$];
  logic [63:0] logSeq [$];
  int          plCnt;
  int          tickNo;
  int          plTick;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N_CH; i++) begin
      chValidIn[i] = lnActive[i];
      chDataIn[i*DATA_W +: DATA_W] = {lnSeq[i][3:0], 4'(lnBeat[i])};
      chLastIn[i] = (lnBeat[i] == lnLen[i] - 1);
      chSeqIn[i*SEQ_W +: SEQ_W] = lnSeq[i];
    end
  endtask

  task automatic startMsg(input int ln, input logic [63:0] seq, input int len);
    lnActive[ln] = 1'b1;
    lnSeq[ln] = seq;
    lnBeat[ln] = 0;
    lnLen[ln] = len;
    drive();
    #1;
  endtask

  task automatic tick();
    logic [N_CH-1:0] xfer;
    xfer = chValidIn & chReadyOut;
    tickNo++;
    if (packetLostOut) begin
      plCnt++;
      plTick = tickNo;
    end
    if (itchDataValidOut && itchReadyIn) begin
      logData.push_back(itchDataOut);
      logLast.push_back(itchLastOut);
      logSeq.push_back(itchSeqOut);
    end
    @(posedge clkIn);
    #1;
    for (int i = 0; i < N_CH; i++) begin
      if (xfer[i]) begin
        if (lnBeat[i] == lnLen[i] - 1) lnActive[i] = 1'b0;
        else lnBeat[i]++;
      end
    end
    drive();
    #1;
  endtask

  task automatic runToIdle(input string tag, input int budget);
    int n;
    n = 0;
    while ((lnActive[0] || lnActive[1] || itchDataValidOut) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 64'(lnActive[0] || lnActive[1] || itchDataValidOut), 64'd0);
  endtask

  task automatic clearLog();
    logData.delete();
    logLast.delete();
    logSeq.delete();
    plCnt = 0;
    tickNo = 0;
    plTick = 0;
  endtask

  task automatic checkMsg(input string tag, input int off, input logic [63:0] seq, input int len);
    for (int b = 0; b < len; b++) begin
      if (off + b < logData.size()) begin
        check({tag, "_data"}, 64'(logData[off+b]), 64'({seq[3:0], 4'(b)}));
        check({tag, "_last"}, 64'(logLast[off+b]), 64'(b == len - 1));
        check({tag, "_seq"}, logSeq[off+b], seq);
      end else begin
        check({tag, "_missing"}, 64'(off + b), 64'(logData.size()));
      end
    end
  endtask

  initial begin
    rstIn = 1'b1;
    itchReadyIn = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      lnActive[i] = 1'b0; lnSeq[i] = '0; lnBeat[i] = 0; lnLen[i] = 1;
    end
    drive();
    clearLog();
    repeat (3) @(posedge clkIn);
    #1;
    check("rst_valid", 64'(itchDataValidOut), 64'd0);
    check("rst_data", 64'(itchDataOut), 64'd0);
    check("rst_last", 64'(itchLastOut), 64'd0);
    check("rst_seq", itchSeqOut, 64'd0);
    check("rst_ready", 64'(chReadyOut), 64'd0);
    check("rst_lost", 64'(packetLostOut), 64'd0);
    check("rst_gap", 64'(gapCountOut), 64'd0);
    check("rst_dup", 64'(dupCountOut), 64'd0);
    rstIn = 1'b0;
    tick();

    // Simultaneous seq 10 on both lines before sync: A forwarded, B dropped
    clearLog();
    startMsg(0, 64'd10, 4);
    startMsg(1, 64'd10, 4);
    runToIdle("t1", 100);
    check("t1_beats", 64'(logData.size()), 64'd4);
    checkMsg("t1", 0, 64'd10, 4);
    check("t1_dup", 64'(dupCountOut), 64'd1);
    check("t1_lost", 64'(plCnt), 64'd0);

    // Gap filled by the other line within the wait window
    clearLog();
    startMsg(0, 64'd12, 2);
    repeat (3) tick();
    startMsg(1, 64'd11, 2);
    runToIdle("t2", 100);
    check("t2_beats", 64'(logData.size()), 64'd4);
    checkMsg("t2a", 0, 64'd11, 2);
    checkMsg("t2b", 2, 64'd12, 2);
    check("t2_gap", 64'(gapCountOut), 64'd0);

    // Unfilled gap: accepted on the 64th IDLE cycle, skipped seq later dropped
    clearLog();
    startMsg(0, 64'd15, 2);
    runToIdle("t3", 200);
    check("t3_lostcnt", 64'(plCnt), 64'd1);
    check("t3_losttick", 64'(plTick), 64'(GAP_WAIT));
    check("t3_gap", 64'(gapCountOut), 64'd1);
    check("t3_beats", 64'(logData.size()), 64'd2);
    checkMsg("t3", 0, 64'd15, 2);
    clearLog();
    startMsg(1, 64'd14, 3);
    runToIdle("t3d", 100);
    check("t3d_beats", 64'(logData.size()), 64'd0);
    check("t3d_dup", 64'(dupCountOut), 64'd2);

    // Downstream backpressure mid-message
    clearLog();
    startMsg(0, 64'd16, 6);
    repeat (3) tick();
    itchReadyIn = 1'b0;
    #1;
    for (int h = 0; h < 5; h++) begin
      check("t4_holdready", 64'(chReadyOut), 64'd0);
      check("t4_holdvalid", 64'(itchDataValidOut), 64'd1);
      tick();
    end
    itchReadyIn = 1'b1;
    #1;
    runToIdle("t4", 100);
    check("t4_beats", 64'(logData.size()), 64'd6);
    checkMsg("t4", 0, 64'd16, 6);

    // Sequence wrap: rebase to all-ones via a gap, then all-ones and 0 in order
    clearLog();
    startMsg(0, 64'hFFFF_FFFF_FFFF_FFFE, 2);
    runToIdle("t5g", 200);
    startMsg(0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    runToIdle("t5a", 100);
    startMsg(1, 64'd0, 2);
    runToIdle("t5b", 100);
    check("t5_beats", 64'(logData.size()), 64'd6);
    checkMsg("t5g", 0, 64'hFFFF_FFFF_FFFF_FFFE, 2);
    checkMsg("t5a", 2, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    checkMsg("t5b", 4, 64'd0, 2);
    check("t5_gap", 64'(gapCountOut), 64'd2);
    check("t5_dup", 64'(dupCountOut), 64'd2);

    // Reset mid-FWD, then resync on an arbitrary head
    clearLog();
    startMsg(0, 64'd5, 8);
    repeat (4) tick();
    rstIn = 1'b1;
    @(posedge clkIn);
    #1;
    lnActive[0] = 1'b0;
    lnActive[1] = 1'b0;
    drive();
    #1;
    check("t6_valid", 64'(itchDataValidOut), 64'd0);
    check("t6_data", 64'(itchDataOut), 64'd0);
    check("t6_seq", itchSeqOut, 64'd0);
    check("t6_ready", 64'(chReadyOut), 64'd0);
    check("t6_gap", 64'(gapCountOut), 64'd0);
    check("t6_dup", 64'(dupCountOut), 64'd0);
    rstIn = 1'b0;
    tick();
    clearLog();
    startMsg(1, 64'd3, 2);
    runToIdle("t6s", 100);
    check("t6s_beats", 64'(logData.size()), 64'd2);
    checkMsg("t6s", 0, 64'd3, 2);
    check("t6s_dup", 64'(dupCountOut), 64'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/moldudp64_line_arbiter.md
# moldudp64_line_arbiter

Parametrised N-line arbiter for redundant MoldUDP64/ITCH feeds (A/B lines and beyond) in the 250 MHz parse domain. It sits between per-line `eth_udp_parser` instances and the book builder. It forwards each sequence number exactly once, silently drops duplicates, and waits a bounded time for another line to fill a gap before declaring loss.

## Interface
Parameters:
- `N_CH` = 2: number of redundant feed lines, 1..8.
- `DATA_W` = 8: message data beat width.
- `SEQ_W` = 64: MoldUDP64 sequence number width.
- `GAP_WAIT` = 64: cycles to wait for an in-order message before accepting a gap, at least 1.
- `CNT_W` = 16: statistics counter width.

Ports:
- `clkIn` in 1: 250 MHz parse clock. This is the only clock; reset is synchronous and active-high.
- `rstIn` in 1: synchronous, active-high reset.
- `chValidIn` in N_CH: per-line beat valid.
- `chDataIn` in N_CH*DATA_W: per-line beat data. Line i occupies `[i*DATA_W +: DATA_W]`.
- `chLastIn` in N_CH: last beat of the message.
- `chSeqIn` in N_CH*SEQ_W: message sequence number. It must be stable for every beat of a message.
- `chReadyOut` out N_CH: per-line beat accept.
- `itchDataValidOut` out 1: output beat valid.
- `itchDataOut` out DATA_W: output beat data.
- `itchLastOut` out 1: last beat of the output message.
- `itchSeqOut` out SEQ_W: sequence number of the output message.
- `itchReadyIn` in 1: downstream accept.
- `packetLostOut` out 1: one-cycle pulse when a gap is accepted.
- `gapCountOut` out CNT_W: accepted gaps. Saturates at all-ones.
- `dupCountOut` out CNT_W: dropped duplicate messages. Saturates at all-ones.

## Operation
- A beat on line i transfers when `chValidIn[i] & chReadyOut[i]`. A line must hold its valid, data, last and seq signals until the beat transfers.
- Internal registers:
  - `expSeq` (SEQ_W): the next sequence number to forward.
  - `synced`: cleared at reset.
  - `sel`: the locked line index.
  - `gapTmr`: gap wait counter, sized to hold `GAP_WAIT`.
- FSM states: IDLE, FWD, DROP. The reset state is IDLE.
- **IDLE.** Each cycle, examine the lines with `chValidIn=1`, which are at a message head. Evaluate in this order and stop at the first match:
  1. A line with `!synced` or `seq==expSeq`, lowest index first: set `sel`, go to FWD, clear `gapTmr`.
  2. A line with `seq<expSeq` (unsigned): set `sel`, go to DROP, clear `gapTmr`.
  3. A line with `seq>expSeq`:
     - If `gapTmr==GAP_WAIT-1`: pick the line with the smallest seq (lowest index on a tie), go to FWD, pulse `packetLostOut` for exactly one cycle, and increment `gapCountOut`.
     - Otherwise: increment `gapTmr`.
  4. No valid line: clear `gapTmr`.
- In IDLE, `chReadyOut` is all zeros.
- **FWD.**
  - `chReadyOut[sel] = !itchDataValidOut | itchReadyIn`. All other lines have ready 0.
  - Each accepted beat is loaded into the output register with data, last and `seq` from line `sel`.
  - When the last beat is accepted: `expSeq <= seq + 1` (mod 2^SEQ_W), `synced <= 1`, go to IDLE.
- **DROP.**
  - `chReadyOut[sel] = 1`; the beats are discarded.
  - When the last beat is accepted: increment `dupCountOut` (saturating) and go to IDLE.
- Other lines stay stalled while a message is locked. They are never dropped mid-message.
- Sequence wrap is not special-cased. The compare is plain unsigned, and `expSeq` wraps from all-ones to 0.
- Gap accept rebases `expSeq` to the accepted seq+1 when that message ends. A line that later delivers the skipped numbers has them dropped as duplicates.
- `N_CH=1` is legal. Gaps are then accepted after `GAP_WAIT` cycles and duplicates are still dropped.

## Timing
- Reset values: `itchDataValidOut=0`, `itchLastOut=0`, `itchDataOut=0`, `itchSeqOut=0`, `chReadyOut=0`, `packetLostOut=0`, both counters 0, `expSeq=0`, `synced=0`, `gapTmr=0`, state IDLE.
- Reset mid-message aborts the lock immediately. No partial-message completion is owed downstream.
- Selection costs one cycle: a head presented in cycle t is selected in t, and its first beat can be accepted in t+1.
- Output is a single register stage. An accepted beat appears on `itch*Out` the next cycle.
- With no backpressure, throughput is one beat per cycle within a message. There is one IDLE bubble between messages.
- The output register holds while `itchDataValidOut & !itchReadyIn`.
- The gap decision fires on the GAP_WAIT-th consecutive IDLE cycle in which only ahead-of-sequence heads are present. Any in-order or duplicate head resets the wait.
- `packetLostOut` is asserted in the same cycle as the FWD transition.
- Counter increments are visible one cycle after the causing event.
- If several lines present heads in the same cycle, the priority order in IDLE decides. Only one line is ever locked.

## Test plan
- Lines A and B present seq 10 (4 beats) at the same time with no sync. A is forwarded, then B's seq 10 is dropped. Output is 4 beats with `itchSeqOut=10`, `dupCountOut=1`, `packetLostOut` never asserted.
- `expSeq=11`. A presents 12; B presents 11 three cycles later (`GAP_WAIT=64`). Output is 11, then 12, with `gapCountOut=0`.
- `expSeq=11`. Only A presents 13, and B stays idle. At the 64th IDLE cycle `packetLostOut` pulses once and 13 is forwarded. `gapCountOut=1`, `expSeq=14`. A later seq 11 or 12 on B is dropped.
- Hold `itchReadyIn=0` for 5 cycles mid-message. No beat is lost or duplicated, and `chReadyOut[sel]` is deasserted during the hold.
- `expSeq` = all-ones. The in-order message is forwarded and `expSeq` wraps to 0. A following seq 0 is forwarded, not dropped.
- Assert `rstIn` mid-FWD. The next cycle shows all reset values. After reset, the first head on any line is accepted as the sync point.
